debug_regs_dumper: RTL and testbench

Downstream consumer of the register file's flattened debug bus. On a start pulse it snapshots all 32 general-purpose registers (1024 bits) and streams them out as 128 bytes over a valid/ready byte interface. The debug unit's UART transmitter sits on the other side of that interface. The snapshot lets the datapath keep running or be reset while the dump drains.

---
 rtl/debug_regs_dumper.sv | 120 ++++++++++++
 tb/tb_debug_regs_dumper.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/debug_regs_dumper.sv
// Snapshots the flattened register-file debug bus on a start pulse and streams it
// out LSB-byte-first, register 0 first, over a registered valid/ready byte port.
module debug_regs_dumper #(
    parameter int PROC_BITS = 32,
    parameter int REG_COUNT = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_start,
    input  logic [PROC_BITS*REG_COUNT-1:0] i_debug_regs,
    input  logic                           i_ready,
    output logic [7:0]                     o_data,
    output logic                           o_valid,
    output logic                           o_busy,
    output logic                           o_done
);

    localparam int TOTAL_BITS = PROC_BITS * REG_COUNT;
    localparam int BYTES      = TOTAL_BITS / 8;
    localparam int CNT_W      = $clog2(BYTES);
    localparam int IDX_W      = $clog2(TOTAL_BITS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [TOTAL_BITS-1:0]   snap_q, snap_d;
    logic [7:0]              data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [IDX_W-1:0]        idx_s;

    // Next-state logic; outputs are derived from the next state so they register
    // in step with it and o_data already shows byte 0 right after the capture edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        snap_d  = snap_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    state_d = ST_SEND;
                    cnt_d   = {CNT_W{1'b0}};
                    snap_d  = i_debug_regs;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (i_ready) begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = {CNT_W{1'b0}};
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase

        idx_s   = IDX_W'({cnt_d, 3'b000});
        valid_d = (state_d == ST_SEND);
        busy_d  = (state_d == ST_SEND);
        done_d  = (state_d == ST_DONE);
        if (state_d == ST_SEND) begin
            data_d = snap_d[idx_s +: 8];
        end else begin
            data_d = 8'd0;
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            data_q  <= 8'd0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Snapshot register; its contents only matter while a dump is in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snap_q <= {TOTAL_BITS{1'b0}};
        end else begin
            snap_q <= snap_d;
        end
    end

    assign o_data  = data_q;
    assign o_valid = valid_q;
    assign o_busy  = busy_q;
    assign o_done  = done_q;

endmodule

// File: tb/tb_debug_regs_dumper.sv
// Bench for debug_regs_dumper: scenario table driven through a byte-level reference
// model, plus hand-written reset sequences.
module tb_debug_regs_dumper;

    localparam int PB = 32;
    localparam int RC = 32;
    localparam int NB = PB * RC / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_start;
    logic [PB*RC-1:0]  i_debug_regs;
    logic              i_ready;
    logic [7:0]        o_data;
    logic              o_valid;
    logic              o_busy;
    logic              o_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    debug_regs_dumper #(.PROC_BITS(PB), .REG_COUNT(RC)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_start      (i_start),
        .i_debug_regs (i_debug_regs),
        .i_ready      (i_ready),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    // mode: 0 = always ready, 1 = ready pattern 1,0,0,1, 2 = random ready
    typedef struct {
        int mode;
        bit poke;
        bit corrupt;
        bit rnd_data;
        int exp_cycles;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [PB*RC-1:0] pattern_regs();
        logic [PB*RC-1:0] r;
        for (int i = 0; i < RC; i++) begin
            r[i*PB +: PB] = 32'hA0B0C000 | 32'(i);
        end
        return r;
    endfunction

    function automatic logic [PB*RC-1:0] random_regs();
        logic [PB*RC-1:0] r;
        for (int i = 0; i < RC; i++) begin
            r[i*PB +: PB] = $urandom;
        end
        return r;
    endfunction

    // Reference: byte k is byte (k mod 4) of register (k div 4).
    function automatic logic [7:0] model_byte(logic [PB*RC-1:0] regs, int k);
        logic [PB-1:0] rv;
        rv = regs[(k / 4) * PB +: PB];
        return 8'(rv >> (8 * (k % 4)));
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle(string tag);
        chk({tag, "_data"},  32'(o_data),  32'd0);
        chk({tag, "_valid"}, 32'(o_valid), 32'd0);
        chk({tag, "_busy"},  32'(o_busy),  32'd0);
        chk({tag, "_done"},  32'(o_done),  32'd0);
    endtask

    task automatic do_dump(vec_t v);
        logic [PB*RC-1:0] regs;
        logic [7:0]       exp_q[$];
        int idx;
        int stalls;
        int cyc;
        regs = v.rnd_data ? random_regs() : pattern_regs();
        exp_q.delete();
        for (int k = 0; k < NB; k++) exp_q.push_back(model_byte(regs, k));

        @(negedge clk);
        i_debug_regs = regs;
        i_start      = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        if (v.corrupt) i_debug_regs = '1;

        idx = 0; stalls = 0; cyc = 0;
        while (!o_done && cyc < 600) begin
            chk("send_valid", 32'(o_valid), 32'd1);
            chk("send_busy",  32'(o_busy),  32'd1);
            if (idx < NB) begin
                chk("byte", 32'(o_data), 32'(exp_q[idx]));
            end else begin
                chk("extra_byte_idx", 32'(idx), 32'(NB - 1));
            end
            case (v.mode)
                0:       i_ready = 1'b1;
                1:       i_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: i_ready = 1'($urandom_range(0, 1));
            endcase
            i_start = (v.poke && idx == 40) ? 1'b1 : 1'b0;
            if (i_ready) idx++; else stalls++;
            cyc++;
            @(negedge clk);
        end
        i_start = 1'b0;
        if (cyc >= 600) begin
            chk("done_timeout", 32'(cyc), 32'd0);
        end
        chk("bytes_sent", 32'(idx), 32'(NB));
        chk("done_latency", 32'(cyc), 32'(NB + stalls));
        if (v.exp_cycles > 0) chk("done_latency_tab", 32'(cyc), 32'(v.exp_cycles));
        chk("done_pulse", 32'(o_done),  32'd1);
        chk("done_valid", 32'(o_valid), 32'd0);
        chk("done_busy",  32'(o_busy),  32'd0);
        chk("done_data",  32'(o_data),  32'd0);
        i_start = v.poke;
        @(negedge clk);
        i_start = 1'b0;
        chk_idle("post_done");
        @(negedge clk);
        chk_idle("post_done2");
    endtask

    initial begin
        vecs[0] = '{mode: 0, poke: 1'b0, corrupt: 1'b0, rnd_data: 1'b0, exp_cycles: 128};
        vecs[1] = '{mode: 1, poke: 1'b0, corrupt: 1'b0, rnd_data: 1'b0, exp_cycles: 256};
        vecs[2] = '{mode: 0, poke: 1'b0, corrupt: 1'b1, rnd_data: 1'b0, exp_cycles: 128};
        vecs[3] = '{mode: 0, poke: 1'b1, corrupt: 1'b0, rnd_data: 1'b0, exp_cycles: 128};
        vecs[4] = '{mode: 2, poke: 1'b0, corrupt: 1'b1, rnd_data: 1'b1, exp_cycles: 0};
        vecs[5] = '{mode: 2, poke: 1'b1, corrupt: 1'b0, rnd_data: 1'b1, exp_cycles: 0};

        rst          = 1'b0;
        i_start      = 1'b0;
        i_ready      = 1'b0;
        i_debug_regs = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            i_start      = 1'($urandom_range(0, 1));
            i_ready      = 1'($urandom_range(0, 1));
            i_debug_regs = random_regs();
            chk_idle("in_reset");
        end
        @(negedge clk);
        i_start = 1'b0;
        i_ready = 1'b1;
        rst     = 1'b1;
        @(negedge clk);
        chk_idle("after_release");

        for (int v = 0; v < 6; v++) do_dump(vecs[v]);

        // Reset mid-dump after byte 50 has been transferred.
        @(negedge clk);
        i_debug_regs = pattern_regs();
        i_ready      = 1'b1;
        i_start      = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (51) @(negedge clk);
        chk("pre_reset_byte", 32'(o_data), 32'(model_byte(pattern_regs(), 51)));
        chk("pre_reset_valid", 32'(o_valid), 32'd1);
        #2 rst = 1'b0;
        #1 chk_idle("async_rst");
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_idle("hold_rst");
        end
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_idle("no_resume");
        end
        do_dump(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
